cu_edge_job_cmd_gen: RTL and testbench

Compute-unit stage directly downstream of the vertex job filter. It pulls one non-zero-degree vertex at a time and splits its edge range into cache-line-sized read commands against the edge array. It emits those commands to the CU read command buffer under ready/valid flow control, and keeps per-vertex and per-command completion counters for CU done detection.

---
 rtl/cu_edge_job_cmd_gen_pkg.sv | 42 ++++
 rtl/cu_edge_job_cmd_gen_if.sv | 24 ++
 rtl/cu_edge_chunk_calc.sv | 29 ++
 rtl/cu_edge_job_cmd_gen.sv | 140 ++++++++++++++
 tb/tb_cu_edge_job_cmd_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_edge_job_cmd_gen_pkg.sv
// Shared types and constants for the CU edge read-command generator.
// Command and vertex layouts mirror the CU command buffer and vertex filter.
package cu_edge_job_cmd_gen_pkg;

    localparam int VERTEX_SIZE_BITS   = 32;
    localparam int CACHELINE_BYTES    = 128;
    localparam int EDGE_BYTES         = 4;
    localparam int CACHELINE_EDGE_NUM = CACHELINE_BYTES / EDGE_BYTES;
    localparam int LINE_IDX_BITS      = $clog2(CACHELINE_EDGE_NUM);
    localparam int CHUNK_BITS         = LINE_IDX_BITS + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        LOAD = 3'd3,
        SEND = 3'd4
    } edge_cmd_gen_state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        READ_EDGE = 2'd1
    } cmd_type_t;

    typedef struct packed {
        logic                        valid;
        logic [VERTEX_SIZE_BITS-1:0] id;
        logic [VERTEX_SIZE_BITS-1:0] out_degree;
        logic [VERTEX_SIZE_BITS-1:0] edges_idx;
    } vertex_interface_t;

    typedef struct packed {
        logic                        valid;
        logic [63:0]                 address;
        logic [7:0]                  size;
        cmd_type_t                   cmd;
        logic [7:0]                  cu_id;
        logic [VERTEX_SIZE_BITS-1:0] vertex_id;
        logic [CHUNK_BITS-1:0]       edge_count;
    } command_buffer_line_t;

endpackage

// File: rtl/cu_edge_job_cmd_gen_if.sv
// Vertex-request and read-command handshake bundle between filter, generator and command buffer.
// master = command generator side, slave = filter / command buffer side.
interface cu_edge_job_cmd_gen_if;
    import cu_edge_job_cmd_gen_pkg::*;

    vertex_interface_t    vertex_in;
    logic                 vertex_request;
    logic                 read_cmd_ready;
    command_buffer_line_t read_cmd_out;

    modport master (
        input  vertex_in,
        input  read_cmd_ready,
        output vertex_request,
        output read_cmd_out
    );

    modport slave (
        output vertex_in,
        output read_cmd_ready,
        input  vertex_request,
        input  read_cmd_out
    );
endinterface

// File: rtl/cu_edge_chunk_calc.sv
// Combinational chunk size / byte address for the next edge read; zero latency, no flow control.
// CU_EDGE_CMD_ALIGN_EN: clip the chunk at the next cache-line boundary instead of a flat 32 edges.
module cu_edge_chunk_calc
    import cu_edge_job_cmd_gen_pkg::*;
(
    input  logic [VERTEX_SIZE_BITS-1:0] i_cur_idx,
    input  logic [VERTEX_SIZE_BITS-1:0] i_remaining,
    input  logic [63:0]                 i_base,
    output logic [CHUNK_BITS-1:0]       o_chunk,
    output logic [63:0]                 o_address,
    output logic [7:0]                  o_size
);

    logic [VERTEX_SIZE_BITS-1:0] w_room;

`ifdef CU_EDGE_CMD_ALIGN_EN
    // Once the first chunk ends on a line boundary every later chunk gets the full line.
    assign w_room = VERTEX_SIZE_BITS'(CACHELINE_EDGE_NUM)
                  - VERTEX_SIZE_BITS'(i_cur_idx[LINE_IDX_BITS-1:0]);
`else
    assign w_room = VERTEX_SIZE_BITS'(CACHELINE_EDGE_NUM);
`endif

    assign o_chunk   = (i_remaining < w_room) ? i_remaining[CHUNK_BITS-1:0]
                                              : w_room[CHUNK_BITS-1:0];
    assign o_address = i_base + (64'(i_cur_idx) * 64'(EDGE_BYTES));
    assign o_size    = 8'(32'(o_chunk) * EDGE_BYTES);

endmodule

// File: rtl/cu_edge_job_cmd_gen.sv
// Splits each requested vertex's edge range into <=128B READ_EDGE commands; inputs and outputs registered (2-cycle min latency).
// Registered read_cmd_ready gates issue; enabled_in low freezes the FSM. Line alignment under CU_EDGE_CMD_ALIGN_EN.
module cu_edge_job_cmd_gen
    import cu_edge_job_cmd_gen_pkg::*;
#(
    parameter logic [7:0] CU_ID = 8'd0
) (
    input  logic                        clock,
    input  logic                        rstn,
    input  logic                        enabled_in,
    input  logic [63:0]                 edge_array_base,
    cu_edge_job_cmd_gen_if.master       cmd_if,
    output logic [VERTEX_SIZE_BITS-1:0] vertex_job_counter_done,
    output logic [VERTEX_SIZE_BITS-1:0] edge_cmd_counter
);

    edge_cmd_gen_state_t         r_state, w_next_state;
    logic                        r_enabled;
    logic                        r_ready;
    vertex_interface_t           r_vertex;
    logic [VERTEX_SIZE_BITS-1:0] r_vertex_id, w_vertex_id;
    logic [VERTEX_SIZE_BITS-1:0] r_cur_idx, w_cur_idx;
    logic [VERTEX_SIZE_BITS-1:0] r_remaining, w_remaining;
    logic [VERTEX_SIZE_BITS-1:0] r_done_cnt, w_done_cnt;
    logic [VERTEX_SIZE_BITS-1:0] r_cmd_cnt, w_cmd_cnt;
    logic                        r_vertex_request, w_vertex_request;
    command_buffer_line_t        r_cmd, w_cmd;

    logic [CHUNK_BITS-1:0]       w_chunk;
    logic [63:0]                 w_address;
    logic [7:0]                  w_size;
    logic                        w_last;

    cu_edge_chunk_calc u_chunk_calc (
        .i_cur_idx   (r_cur_idx),
        .i_remaining (r_remaining),
        .i_base      (edge_array_base),
        .o_chunk     (w_chunk),
        .o_address   (w_address),
        .o_size      (w_size)
    );

    assign w_last = (r_remaining == VERTEX_SIZE_BITS'(w_chunk));

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_enabled) begin
            case (r_state)
                IDLE:    w_next_state = REQ;
                REQ:     w_next_state = WAIT;
                WAIT:    if (r_vertex.valid) w_next_state = LOAD;
                LOAD:    w_next_state = (r_remaining == '0) ? REQ : SEND;
                SEND:    if (r_ready && w_last) w_next_state = REQ;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Vertex fields are captured on the WAIT->LOAD edge because the filter's valid is a one-cycle pulse.
    always_comb begin
        w_vertex_request = 1'b0;
        w_cmd            = '0;
        w_vertex_id      = r_vertex_id;
        w_cur_idx        = r_cur_idx;
        w_remaining      = r_remaining;
        w_done_cnt       = r_done_cnt;
        w_cmd_cnt        = r_cmd_cnt;
        if (r_enabled) begin
            case (r_state)
                REQ: w_vertex_request = 1'b1;
                WAIT: begin
                    if (r_vertex.valid) begin
                        w_vertex_id = r_vertex.id;
                        w_cur_idx   = r_vertex.edges_idx;
                        w_remaining = r_vertex.out_degree;
                    end
                end
                LOAD: begin
                    if (r_remaining == '0) w_done_cnt = r_done_cnt + 1'b1;
                end
                SEND: begin
                    if (r_ready) begin
                        w_cmd.valid      = 1'b1;
                        w_cmd.address    = w_address;
                        w_cmd.size       = w_size;
                        w_cmd.cmd        = READ_EDGE;
                        w_cmd.cu_id      = CU_ID;
                        w_cmd.vertex_id  = r_vertex_id;
                        w_cmd.edge_count = w_chunk;
                        w_cur_idx        = r_cur_idx + VERTEX_SIZE_BITS'(w_chunk);
                        w_remaining      = r_remaining - VERTEX_SIZE_BITS'(w_chunk);
                        w_cmd_cnt        = r_cmd_cnt + 1'b1;
                        if (w_last) w_done_cnt = r_done_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_enabled        <= 1'b0;
            r_ready          <= 1'b0;
            r_vertex         <= '0;
            r_vertex_id      <= '0;
            r_cur_idx        <= '0;
            r_remaining      <= '0;
            r_done_cnt       <= '0;
            r_cmd_cnt        <= '0;
            r_vertex_request <= 1'b0;
            r_cmd            <= '0;
        end else begin
            r_enabled        <= enabled_in;
            r_ready          <= cmd_if.read_cmd_ready;
            r_vertex         <= cmd_if.vertex_in;
            r_vertex_id      <= w_vertex_id;
            r_cur_idx        <= w_cur_idx;
            r_remaining      <= w_remaining;
            r_done_cnt       <= w_done_cnt;
            r_cmd_cnt        <= w_cmd_cnt;
            r_vertex_request <= w_vertex_request;
            r_cmd            <= w_cmd;
        end
    end

    assign cmd_if.vertex_request = r_vertex_request;
    assign cmd_if.read_cmd_out   = r_cmd;
    assign vertex_job_counter_done = r_done_cnt;
    assign edge_cmd_counter        = r_cmd_cnt;

endmodule

// File: tb/tb_cu_edge_job_cmd_gen.sv
// Directed bench for cu_edge_job_cmd_gen: command splitting, backpressure, zero degree, wrap, disable and reset.
// Expected command tables switch with CU_EDGE_CMD_ALIGN_EN.
module tb_cu_edge_job_cmd_gen;
    import cu_edge_job_cmd_gen_pkg::*;

    logic        clock = 1'b0;
    logic        rstn  = 1'b1;
    logic        enabled_in = 1'b0;
    logic [63:0] edge_array_base = '0;
    logic [VERTEX_SIZE_BITS-1:0] vertex_job_counter_done;
    logic [VERTEX_SIZE_BITS-1:0] edge_cmd_counter;

    cu_edge_job_cmd_gen_if cmd_if ();

    cu_edge_job_cmd_gen #(.CU_ID(8'd0)) dut (
        .clock                   (clock),
        .rstn                    (rstn),
        .enabled_in              (enabled_in),
        .edge_array_base         (edge_array_base),
        .cmd_if                  (cmd_if),
        .vertex_job_counter_done (vertex_job_counter_done),
        .edge_cmd_counter        (edge_cmd_counter)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cnt = 0;
    int last_req_cyc = 0;
    int req_used = 0;
    int cmd_base = 0;
    command_buffer_line_t cmd_q[$];
    int cmd_cyc_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (cmd_if.read_cmd_out.valid === 1'b1) begin
            cmd_q.push_back(cmd_if.read_cmd_out);
            cmd_cyc_q.push_back(cyc);
        end
        if (cmd_if.vertex_request === 1'b1) begin
            req_cnt = req_cnt + 1;
            last_req_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        enabled_in = 1'b0;
        cmd_if.vertex_in = '0;
        cmd_if.read_cmd_ready = 1'b0;
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
        cmd_base = cmd_q.size();
        req_used = req_cnt;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 100 && req_cnt <= req_used; i++) tick(1);
        checks++;
        if (req_cnt <= req_used) begin
            errors++;
            $display("FAIL %s vertex_request not seen: requests %0d required > %0d", name, req_cnt, req_used);
        end
        req_used = req_cnt;
    endtask

    task automatic deliver(input logic [31:0] id, input logic [31:0] deg, input logic [31:0] idx);
        wait_req("deliver_req");
        cmd_if.vertex_in = {1'b1, id, deg, idx};
        tick(1);
        cmd_if.vertex_in = '0;
    endtask

    task automatic wait_cmds(input int n, input string name);
        for (int i = 0; i < 200 && cmd_q.size() < cmd_base + n; i++) tick(1);
        checks++;
        if (cmd_q.size() < cmd_base + n) begin
            errors++;
            $display("FAIL %s command timeout: got %0d required %0d", name, cmd_q.size() - cmd_base, n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (cmd_if.read_cmd_out !== '0) begin
            errors++;
            $display("FAIL reset_cmd got %h required 0", cmd_if.read_cmd_out);
        end
        checks++;
        if (cmd_if.vertex_request !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got %b required 0", cmd_if.vertex_request);
        end
        checks++;
        if (edge_cmd_counter !== '0 || vertex_job_counter_done !== '0) begin
            errors++;
            $display("FAIL reset_counters got cmd %0d done %0d required 0 0", edge_cmd_counter, vertex_job_counter_done);
        end
        do_reset();
        tick(6);
        checks++;
        if (req_cnt != req_used) begin
            errors++;
            $display("FAIL reset_idle_req got %0d requests while disabled required 0", req_cnt - req_used);
        end
    endtask

    task automatic test_split();
        logic [63:0] ea[3];
        int          ec[3];
        command_buffer_line_t c;
`ifdef CU_EDGE_CMD_ALIGN_EN
        ea[0] = 64'h1028; ea[1] = 64'h1080; ea[2] = 64'h1100;
        ec[0] = 22;       ec[1] = 32;       ec[2] = 16;
`else
        ea[0] = 64'h1028; ea[1] = 64'h10A8; ea[2] = 64'h1128;
        ec[0] = 32;       ec[1] = 32;       ec[2] = 6;
`endif
        do_reset();
        edge_array_base = 64'h1000;
        cmd_if.read_cmd_ready = 1'b1;
        enabled_in = 1'b1;
        deliver(32'd5, 32'd70, 32'd10);
        wait_cmds(3, "split");
        tick(2);
        for (int k = 0; k < 3; k++) begin
            c = (cmd_q.size() > cmd_base + k) ? cmd_q[cmd_base + k] : '0;
            checks++;
            if (c.address !== ea[k] || c.size !== 8'(ec[k] * 4) || c.edge_count !== 6'(ec[k])) begin
                errors++;
                $display("FAIL split_cmd%0d got addr %h size %0d cnt %0d required addr %h size %0d cnt %0d",
                         k, c.address, c.size, c.edge_count, ea[k], ec[k] * 4, ec[k]);
            end
            checks++;
            if (c.cmd !== READ_EDGE || c.vertex_id !== 32'd5 || c.cu_id !== 8'd0) begin
                errors++;
                $display("FAIL split_tag%0d got cmd %0d vid %0d cu %0d required 1 5 0", k, c.cmd, c.vertex_id, c.cu_id);
            end
        end
        checks++;
        if (cmd_q.size() != cmd_base + 3) begin
            errors++;
            $display("FAIL split_count got %0d commands required 3", cmd_q.size() - cmd_base);
        end
        checks++;
        if (edge_cmd_counter !== 32'd3 || vertex_job_counter_done !== 32'd1) begin
            errors++;
            $display("FAIL split_counters got cmd %0d done %0d required 3 1", edge_cmd_counter, vertex_job_counter_done);
        end
        // back-to-back: the next request lands the cycle after the final command
        wait_req("b2b_req");
        checks++;
        if (last_req_cyc != cmd_cyc_q[cmd_q.size() - 1] + 1) begin
            errors++;
            $display("FAIL back_to_back got request cycle %0d required %0d", last_req_cyc, cmd_cyc_q[cmd_q.size() - 1] + 1);
        end
    endtask

    task automatic test_backpressure();
        logic pat[4];
        int   start;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        do_reset();
        edge_array_base = 64'h1000;
        enabled_in = 1'b1;
        deliver(32'd7, 32'd64, 32'd0);
        tick(6);
        checks++;
        if (cmd_q.size() != cmd_base) begin
            errors++;
            $display("FAIL bp_stall got %0d commands while not ready required 0", cmd_q.size() - cmd_base);
        end
        start = cyc;
        for (int i = 0; i < 4; i++) begin
            cmd_if.read_cmd_ready = pat[i];
            tick(1);
        end
        cmd_if.read_cmd_ready = 1'b0;
        tick(6);
        checks++;
        if (cmd_q.size() != cmd_base + 2) begin
            errors++;
            $display("FAIL bp_count got %0d commands required 2", cmd_q.size() - cmd_base);
        end else begin
            checks++;
            if (cmd_q[cmd_base].address !== 64'h1000 || cmd_q[cmd_base + 1].address !== 64'h1080) begin
                errors++;
                $display("FAIL bp_addr got %h %h required 1000 1080", cmd_q[cmd_base].address, cmd_q[cmd_base + 1].address);
            end
            checks++;
            if (cmd_cyc_q[cmd_base] != start + 2 || cmd_cyc_q[cmd_base + 1] != start + 5) begin
                errors++;
                $display("FAIL bp_timing got cycles %0d %0d required %0d %0d",
                         cmd_cyc_q[cmd_base], cmd_cyc_q[cmd_base + 1], start + 2, start + 5);
            end
        end
        checks++;
        if (edge_cmd_counter !== 32'd2 || vertex_job_counter_done !== 32'd1) begin
            errors++;
            $display("FAIL bp_counters got cmd %0d done %0d required 2 1", edge_cmd_counter, vertex_job_counter_done);
        end
    endtask

    task automatic test_zero_degree();
        do_reset();
        edge_array_base = 64'h1000;
        cmd_if.read_cmd_ready = 1'b1;
        enabled_in = 1'b1;
        deliver(32'd9, 32'd0, 32'd100);
        wait_req("zero_rereq");
        checks++;
        if (cmd_q.size() != cmd_base) begin
            errors++;
            $display("FAIL zero_nocmd got %0d commands required 0", cmd_q.size() - cmd_base);
        end
        checks++;
        if (vertex_job_counter_done !== 32'd1 || edge_cmd_counter !== 32'd0) begin
            errors++;
            $display("FAIL zero_counters got done %0d cmd %0d required 1 0", vertex_job_counter_done, edge_cmd_counter);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        edge_array_base = 64'hFFFF_FFFF_FFFF_FFF0;
        cmd_if.read_cmd_ready = 1'b1;
        enabled_in = 1'b1;
        deliver(32'd3, 32'd2, 32'd8);
        wait_cmds(1, "wrap");
        checks++;
        if (cmd_q.size() <= cmd_base || cmd_q[cmd_base].address !== 64'h10 ||
            cmd_q[cmd_base].size !== 8'd8 || cmd_q[cmd_base].edge_count !== 6'd2) begin
            errors++;
            $display("FAIL wrap_cmd got %h required addr 10 size 8 cnt 2",
                     (cmd_q.size() > cmd_base) ? cmd_q[cmd_base] : '0);
        end
    endtask

    task automatic test_disable();
        int n_frozen;
        logic [31:0] cnt_frozen;
        do_reset();
        edge_array_base = 64'h2000;
        cmd_if.read_cmd_ready = 1'b1;
        enabled_in = 1'b1;
        deliver(32'd11, 32'd96, 32'd0);
        wait_cmds(1, "dis_first");
        enabled_in = 1'b0;
        tick(2);
        n_frozen = cmd_q.size();
        cnt_frozen = edge_cmd_counter;
        tick(5);
        checks++;
        if (cmd_q.size() != n_frozen || edge_cmd_counter !== cnt_frozen || cmd_if.read_cmd_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL dis_frozen got %0d cmds counter %0d required %0d cmds counter %0d",
                     cmd_q.size(), edge_cmd_counter, n_frozen, cnt_frozen);
        end
        enabled_in = 1'b1;
        wait_cmds(3, "dis_resume");
        tick(4);
        checks++;
        if (cmd_q.size() != cmd_base + 3) begin
            errors++;
            $display("FAIL dis_count got %0d commands required 3", cmd_q.size() - cmd_base);
        end else begin
            checks++;
            if (cmd_q[cmd_base].address !== 64'h2000 || cmd_q[cmd_base + 1].address !== 64'h2080 ||
                cmd_q[cmd_base + 2].address !== 64'h2100) begin
                errors++;
                $display("FAIL dis_order got %h %h %h required 2000 2080 2100",
                         cmd_q[cmd_base].address, cmd_q[cmd_base + 1].address, cmd_q[cmd_base + 2].address);
            end
        end
        checks++;
        if (edge_cmd_counter !== 32'd3 || vertex_job_counter_done !== 32'd1) begin
            errors++;
            $display("FAIL dis_counters got cmd %0d done %0d required 3 1", edge_cmd_counter, vertex_job_counter_done);
        end
    endtask

    task automatic test_reset_mid_send();
        int n_after;
        do_reset();
        edge_array_base = 64'h1000;
        cmd_if.read_cmd_ready = 1'b1;
        enabled_in = 1'b1;
        deliver(32'd13, 32'd96, 32'd0);
        wait_cmds(1, "rst_first");
        rstn = 1'b0;
        enabled_in = 1'b0;
        #1;
        checks++;
        if (cmd_if.read_cmd_out !== '0 || cmd_if.vertex_request !== 1'b0 ||
            edge_cmd_counter !== '0 || vertex_job_counter_done !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got valid %b req %b cmd %0d done %0d required all 0",
                     cmd_if.read_cmd_out.valid, cmd_if.vertex_request, edge_cmd_counter, vertex_job_counter_done);
        end
        tick(2);
        rstn = 1'b1;
        req_used = req_cnt;
        n_after = cmd_q.size();
        tick(10);
        checks++;
        if (req_cnt != req_used || cmd_q.size() != n_after) begin
            errors++;
            $display("FAIL rst_mid_idle got %0d requests %0d cmds after reset required 0 0",
                     req_cnt - req_used, cmd_q.size() - n_after);
        end
        enabled_in = 1'b1;
        wait_req("rst_mid_rereq");
    endtask

    initial begin
        cmd_if.vertex_in = '0;
        cmd_if.read_cmd_ready = 1'b0;
        test_reset();
        test_split();
        test_backpressure();
        test_zero_degree();
        test_wrap();
        test_disable();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
